// File: rtl/lane_deserializer_4_pkg.sv
// Shared constants and helpers for the four-lane serial deserializer.
package lane_deserializer_4_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  // A lane counter must hold every value from 0 up to and including WIDTH.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lane_deserializer_4_lane_shift_unit.sv
// One lane: a shift register that collects WIDTH serial bits (first bit ends
// up as the MSB), a fill counter, and the valid/ready handshake for the word.
module lane_shift_unit
  import lane_deserializer_4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic             i_laneReady,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int             CW         = cntWidth(WIDTH);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(WIDTH);

  logic [WIDTH-1:0] r_shiftReg;
  logic [CW-1:0]    r_count;
  logic             w_drain;

  assign o_valid = (r_count == FULL_COUNT);
  assign o_data  = r_shiftReg;
  assign w_drain = o_valid && i_laneReady;

  // Shift in accepted bits; a drain coinciding with an accept starts the next
  // word at count 1 so the new bit is neither lost nor delayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shiftReg <= '0;
      r_count    <= '0;
    end else begin
      if (i_accept) begin
        r_shiftReg <= {r_shiftReg[WIDTH-2:0], i_bit};
      end
      if (w_drain && i_accept) begin
        r_count <= CW'(1);
      end else if (w_drain) begin
        r_count <= '0;
      end else if (i_accept) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lane_deserializer_4.sv
// Four-lane serial deserializer: routes each tagged bit to its lane, and
// stalls the source only when the addressed lane is holding a full word that
// its consumer is not taking this cycle. in_ready depends combinationally on
// lane_ready (never on in_valid), so integrators must budget that path.
module lane_deserializer_4
  import lane_deserializer_4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_bit,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_LANES*WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES-1:0]       lane_ready
);

  logic                 w_accept;
  logic [NUM_LANES-1:0] w_acceptOneHot;

  assign in_ready = !lane_valid[in_sel] || lane_ready[in_sel];
  assign w_accept = in_valid && in_ready;

  // Decode the lane select into a one-hot accept enable.
  always_comb begin
    w_acceptOneHot = '0;
    if (w_accept) begin
      w_acceptOneHot[in_sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    lane_shift_unit #(
      .WIDTH(WIDTH)
    ) uLane (
      .clk        (clk),
      .rst        (rst),
      .i_accept   (w_acceptOneHot[k]),
      .i_bit      (in_bit),
      .i_laneReady(lane_ready[k]),
      .o_data     (lane_data[k*WIDTH +: WIDTH]),
      .o_valid    (lane_valid[k])
    );
  end

endmodule

// File: tb/tb_lane_deserializer_4.sv
// Self-checking bench for lane_deserializer_4 with directed scenarios and a
// randomized run against a word-level reference model.
module tb_lane_deserializer_4;

  localparam int WIDTH = 8;
  localparam int NL    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_bit;
  logic [1:0]        in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [NL*WIDTH-1:0] lane_data;
  logic [NL-1:0]     lane_valid;
  logic [NL-1:0]     lane_ready;

  int passCount  = 0;
  int checkCount = 0;

  // Reference model: per lane, the partially collected word as a number and
  // how many bits it holds, plus a held complete word awaiting consumption.
  bit          mFull[NL];
  int unsigned mWord[NL];
  int unsigned mAcc[NL];
  int          mCnt[NL];

  lane_deserializer_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] laneWord(input int k);
    return lane_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic bit modelReady();
    int s;
    s = int'(in_sel);
    return !mFull[s] || lane_ready[s];
  endfunction

  function automatic logic [NL-1:0] modelValid();
    logic [NL-1:0] v;
    for (int k = 0; k < NL; k++) v[k] = mFull[k];
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NL; k++) begin
      mFull[k] = 1'b0;
      mWord[k] = 0;
      mAcc[k]  = 0;
      mCnt[k]  = 0;
    end
  endtask

  task automatic modelEdge();
    bit acc;
    int s;
    acc = in_valid && modelReady();
    s   = int'(in_sel);
    for (int k = 0; k < NL; k++) begin
      if (mFull[k] && lane_ready[k]) mFull[k] = 1'b0;
    end
    if (acc) begin
      mAcc[s] = ((mAcc[s] * 2) + int'(in_bit)) & ((1 << WIDTH) - 1);
      mCnt[s] = mCnt[s] + 1;
      if (mCnt[s] == WIDTH) begin
        mFull[s] = 1'b1;
        mWord[s] = mAcc[s];
        mAcc[s]  = 0;
        mCnt[s]  = 0;
      end
    end
  endtask

  // Advance one clock with the inputs the caller already set; returns at the
  // following falling edge with the model updated for that rising edge.
  task automatic driveCycle();
    #1;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic b);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bit   = b;
    driveCycle();
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [1:0] sel, input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(sel, w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_bit = 1'b0; lane_ready = 4'b0000;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkCount++;
    if (lane_valid !== 4'b0000 || lane_data !== '0 || in_ready !== 1'b1)
      $display("[TB] FAIL reset_idle: got valid=%b data=%h ready=%b expected 0000/0/1", lane_valid, lane_data, in_ready);
    else passCount++;
    @(negedge clk);
    sendWord(2'd0, 8'hFF);
    checkCount++;
    if (lane_valid !== 4'b0001 || laneWord(0) !== 8'hFF)
      $display("[TB] FAIL reset_prefill: got valid=%b data=%h expected 0001/ff", lane_valid, laneWord(0));
    else passCount++;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkCount++;
    if (lane_valid !== 4'b0000 || lane_data !== '0 || in_ready !== 1'b1)
      $display("[TB] FAIL reset_async: got valid=%b data=%h ready=%b expected 0000/0/1", lane_valid, lane_data, in_ready);
    else passCount++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    lane_ready = 4'b1111;
    sendWord(2'd2, 8'hB2);
    checkCount++;
    if (lane_valid !== 4'b0100 || laneWord(2) !== 8'hB2)
      $display("[TB] FAIL single_word: got valid=%b data=%h expected 0100/b2", lane_valid, laneWord(2));
    else passCount++;
    checkCount++;
    if (laneWord(0) !== 8'h00 || laneWord(1) !== 8'h00 || laneWord(3) !== 8'h00)
      $display("[TB] FAIL single_others: got %h expected 00 in lanes 0,1,3", lane_data);
    else passCount++;
    driveCycle();
    checkCount++;
    if (lane_valid !== 4'b0000)
      $display("[TB] FAIL single_one_cycle: got valid=%b expected 0000", lane_valid);
    else passCount++;
  endtask

  task automatic test_backpressure();
    lane_ready = 4'b1101;
    sendWord(2'd1, 8'hA5);
    checkCount++;
    if (lane_valid !== 4'b0010 || laneWord(1) !== 8'hA5)
      $display("[TB] FAIL bp_full: got valid=%b data=%h expected 0010/a5", lane_valid, laneWord(1));
    else passCount++;
    in_valid = 1'b1; in_sel = 2'd1; in_bit = 1'b1;
    #1;
    checkCount++;
    if (in_ready !== 1'b0)
      $display("[TB] FAIL bp_stall_ready: got %b expected 0", in_ready);
    else passCount++;
    driveCycle();
    checkCount++;
    if (lane_valid !== 4'b0010 || laneWord(1) !== 8'hA5)
      $display("[TB] FAIL bp_hold: got valid=%b data=%h expected 0010/a5", lane_valid, laneWord(1));
    else passCount++;
    lane_ready = 4'b1111;
    #1;
    checkCount++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
    else passCount++;
    driveCycle();
    in_valid = 1'b0;
    checkCount++;
    if (lane_valid !== 4'b0000)
      $display("[TB] FAIL bp_drain: got valid=%b expected 0000", lane_valid);
    else passCount++;
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(2'd1, 1'b0);
    checkCount++;
    if (lane_valid !== 4'b0010 || laneWord(1) !== 8'h80)
      $display("[TB] FAIL bp_next_word: got valid=%b data=%h expected 0010/80", lane_valid, laneWord(1));
    else passCount++;
    driveCycle();
  endtask

  task automatic test_interleave();
    logic [WIDTH-1:0] w0, w3;
    w0 = 8'h0F; w3 = 8'hF0;
    lane_ready = 4'b0000;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(2'd0, w0[i]);
      applyStimulus(2'd3, w3[i]);
    end
    checkCount++;
    if (lane_valid !== 4'b1001 || laneWord(0) !== 8'h0F || laneWord(3) !== 8'hF0)
      $display("[TB] FAIL interleave: got valid=%b l0=%h l3=%h expected 1001/0f/f0", lane_valid, laneWord(0), laneWord(3));
    else passCount++;
    lane_ready = 4'b1111;
    driveCycle();
    checkCount++;
    if (lane_valid !== 4'b0000)
      $display("[TB] FAIL interleave_multi_drain: got valid=%b expected 0000", lane_valid);
    else passCount++;
  endtask

  task automatic test_independence();
    logic [WIDTH-1:0] w0;
    int bad;
    w0 = WIDTH'($urandom);
    bad = 0;
    lane_ready = 4'b1110;
    sendWord(2'd0, w0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(2'd1, (8'h5A >> i) & 1'b1);
      if (lane_valid[0] !== 1'b1 || laneWord(0) !== w0) bad++;
    end
    checkCount++;
    if (bad != 0)
      $display("[TB] FAIL indep_stall_hold: got %0d disturbed cycles expected 0", bad);
    else passCount++;
    checkCount++;
    if (lane_valid !== 4'b0011 || laneWord(1) !== 8'h5A)
      $display("[TB] FAIL indep_lane1: got valid=%b data=%h expected 0011/5a", lane_valid, laneWord(1));
    else passCount++;
    lane_ready = 4'b1111;
    driveCycle();
  endtask

  task automatic test_reset_mid_word();
    lane_ready = 4'b1111;
    for (int i = 0; i < 5; i++) applyStimulus(2'd3, 1'b1);
    #3 rst = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    sendWord(2'd3, 8'h3C);
    checkCount++;
    if (lane_valid !== 4'b1000 || laneWord(3) !== 8'h3C)
      $display("[TB] FAIL reset_mid_word: got valid=%b data=%h expected 1000/3c", lane_valid, laneWord(3));
    else passCount++;
    driveCycle();
  endtask

  task automatic checkOutput_random(input int cycles);
    int readyErr, validErr, dataErr;
    readyErr = 0; validErr = 0; dataErr = 0;
    for (int c = 0; c < cycles; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 2'($urandom);
      in_bit     = 1'($urandom);
      lane_ready = 4'($urandom);
      #1;
      if (in_ready !== modelReady()) begin
        readyErr++;
        if (readyErr == 1)
          $display("[TB] FAIL random_ready: cycle %0d got %b expected %b", c, in_ready, modelReady());
      end
      driveCycle();
      if (lane_valid !== modelValid()) begin
        validErr++;
        if (validErr == 1)
          $display("[TB] FAIL random_valid: cycle %0d got %b expected %b", c, lane_valid, modelValid());
      end
      for (int k = 0; k < NL; k++) begin
        if (mFull[k] && laneWord(k) !== WIDTH'(mWord[k])) begin
          dataErr++;
          if (dataErr == 1)
            $display("[TB] FAIL random_data: cycle %0d lane %0d got %h expected %h", c, k, laneWord(k), mWord[k]);
        end
      end
    end
    in_valid = 1'b0;
    checkCount++;
    if (readyErr == 0) passCount++;
    checkCount++;
    if (validErr == 0) passCount++;
    checkCount++;
    if (dataErr == 0) passCount++;
  endtask

  // Run each scenario in order, then report.
  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_interleave();
    test_independence();
    test_reset_mid_word();
    checkOutput_random(400);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
